// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops scan-code bytes from the ps2_keyboard FIFO one at a time
// and decodes set-2 prefixes (0xE0 extended, 0xF0 break) into held-key state,
// a wrapping press counter and, when PS2_KEY_ASCII_EN is defined, an ASCII code.
// Each byte takes three cycles: IDLE (capture), POP (pop + decode), SETTLE.
module ps2_key_ctrl #(
  parameter int COUNT_W        = 8,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [7:0]         fifo_data,
  input  logic               fifo_ready,
  input  logic               fifo_overflow,
  output logic               nextdata_n,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_valid,
  output logic               key_strobe,
  output logic [COUNT_W-1:0] press_count,
  output logic [7:0]         ascii,
  output logic               ovf_sticky
);

  localparam int TMO_W = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam bit TMO_EN = (PREFIX_TIMEOUT > 0);
  localparam logic [TMO_W-1:0] TMO_RELOAD =
    (PREFIX_TIMEOUT > 0) ? TMO_W'(PREFIX_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nx;
  logic [7:0]         byte_r;
  logic               ext_pend_r;
  logic               brk_pend_r;
  logic [TMO_W-1:0]   tmo_r;

  logic               ext_nx;
  logic               brk_nx;
  logic [TMO_W-1:0]   tmo_nx;
  logic [7:0]         code_nx;
  logic               kext_nx;
  logic               valid_nx;
  logic [COUNT_W-1:0] cnt_nx;
  logic               make_nx;
  logic               any_pend;
  logic               is_ack;
  logic               held_match;
  logic               tmo_active;

  // The pop request is only ever low during POP and never while reset is held.
  assign nextdata_n = ~(resetn && (state_r == POP));

  // Next-state logic for the IDLE -> POP -> SETTLE byte sequencer.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (fifo_ready) begin
          state_nx = POP;
        end else begin
          state_nx = IDLE;
        end
      end
      POP:     state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte decode in POP, plus prefix aging while starved in IDLE.
  always_comb begin
    any_pend   = ext_pend_r | brk_pend_r;
    is_ack     = (byte_r == 8'hAA) || (byte_r == 8'hFA) || (byte_r == 8'hEE);
    held_match = key_valid && (byte_r == key_code) && (ext_pend_r == key_ext);
    tmo_active = TMO_EN && (state_r == IDLE) && !fifo_ready && any_pend;
    ext_nx     = ext_pend_r;
    brk_nx     = brk_pend_r;
    tmo_nx     = tmo_r;
    code_nx    = key_code;
    kext_nx    = key_ext;
    valid_nx   = key_valid;
    cnt_nx     = press_count;
    make_nx    = 1'b0;
    if (state_r == POP) begin
      if (byte_r == 8'hE0) begin
        ext_nx = 1'b1;
        tmo_nx = TMO_RELOAD;
      end else if (byte_r == 8'hF0) begin
        brk_nx = 1'b1;
        tmo_nx = TMO_RELOAD;
      end else if (is_ack && !any_pend) begin
        // Keyboard status bytes outside a prefix carry no key information.
        valid_nx = key_valid;
      end else if (brk_pend_r) begin
        // Only the release of the tracked key drops key_valid.
        if (held_match) begin
          valid_nx = 1'b0;
        end else begin
          valid_nx = key_valid;
        end
        ext_nx = 1'b0;
        brk_nx = 1'b0;
      end else begin
        // A make of the held key is a typematic repeat; anything else is new.
        if (held_match) begin
          make_nx = 1'b0;
        end else begin
          code_nx  = byte_r;
          kext_nx  = ext_pend_r;
          valid_nx = 1'b1;
          cnt_nx   = press_count + COUNT_W'(1);
          make_nx  = 1'b1;
        end
        ext_nx = 1'b0;
      end
    end else if (tmo_active) begin
      if (tmo_r == '0) begin
        ext_nx = 1'b0;
        brk_nx = 1'b0;
      end else begin
        tmo_nx = tmo_r - TMO_W'(1);
      end
    end else begin
      tmo_nx = tmo_r;
    end
  end

  // State, captured byte, prefix flags and key outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      byte_r      <= 8'h00;
      ext_pend_r  <= 1'b0;
      brk_pend_r  <= 1'b0;
      tmo_r       <= '0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      key_strobe  <= 1'b0;
      press_count <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      state_r <= state_nx;
      if ((state_r == IDLE) && fifo_ready) begin
        byte_r <= fifo_data;
      end
      ext_pend_r  <= ext_nx;
      brk_pend_r  <= brk_nx;
      tmo_r       <= tmo_nx;
      key_code    <= code_nx;
      key_ext     <= kext_nx;
      key_valid   <= valid_nx;
      key_strobe  <= make_nx;
      press_count <= cnt_nx;
      if (fifo_overflow) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

`ifdef PS2_KEY_ASCII_EN
  // Set-2 make code to ASCII; extended keys have no ASCII equivalent.
  function automatic logic [7:0] set2_ascii(input logic [7:0] code, input logic ext);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return ext ? 8'h00 : a;
  endfunction

  // ascii follows key_code on the same edge, only when a new make lands.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ascii <= 8'h00;
    end else if (make_nx) begin
      ascii <= set2_ascii(code_nx, kext_nx);
    end
  end
`else
  assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized bench for ps2_key_ctrl: a queue-based FIFO feeds scan codes and a
// rule-level key model predicts held key, counter, strobe and ASCII per byte.
module tb_ps2_key_ctrl;

  localparam int CW = 2;
  localparam int PT = 4;
`ifdef PS2_KEY_ASCII_EN
  localparam bit ASCII_ON = 1'b1;
`else
  localparam bit ASCII_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic [7:0]    fifo_data;
  logic          fifo_ready;
  logic          fifo_overflow;
  logic          nextdata_n;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_valid;
  logic          key_strobe;
  logic [CW-1:0] press_count;
  logic [7:0]    ascii;
  logic          ovf_sticky;

  ps2_key_ctrl #(.COUNT_W(CW), .PREFIX_TIMEOUT(PT)) dut (
    .clk(clk), .resetn(resetn), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
    .fifo_overflow(fifo_overflow), .nextdata_n(nextdata_n), .key_code(key_code),
    .key_ext(key_ext), .key_valid(key_valid), .key_strobe(key_strobe),
    .press_count(press_count), .ascii(ascii), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO contents and per-byte arrival attributes
  logic [7:0] q_data[$];
  bit         q_long[$];
  bit         q_space[$];
  bit         first_in_batch;
  int         hold = 0;
  int         cyc = 0;
  int         last_pop = -1;
  int         pops = 0;
  int         pushed = 0;
  bit         pend_chk = 1'b0;

  // key model
  bit         m_ext, m_brk, m_valid, m_kext, m_strobe;
  logic [7:0] m_code, m_ascii;
  int         m_cnt;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                               8'h35, 8'h1A};
  logic [7:0] digits [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46};
  logic [7:0] pool [11]    = '{8'hE0, 8'hF0, 8'hAA, 8'h1C, 8'h16, 8'h75, 8'h45, 8'h29,
                               8'h5A, 8'h1A, 8'h32};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit e);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == c) r = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (digits[i] == c) r = 8'h30 + 8'(i);
    if (c == 8'h29) r = 8'h20;
    if (c == 8'h5A) r = 8'h0D;
    if (e || !ASCII_ON) r = 8'h00;
    return r;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_valid = 0; m_kext = 0; m_strobe = 0;
    m_code = 8'h00; m_ascii = 8'h00; m_cnt = 0;
  endtask

  // Apply the key-tracking rules to one popped byte.
  task automatic model_apply(input logic [7:0] b, input bit long_gap);
    m_strobe = 0;
    if (long_gap) begin m_ext = 0; m_brk = 0; end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if ((b == 8'hAA || b == 8'hFA || b == 8'hEE) && !m_ext && !m_brk) m_strobe = 0;
    else if (m_brk) begin
      if (m_valid && b == m_code && m_ext == m_kext) m_valid = 0;
      m_ext = 0; m_brk = 0;
    end else begin
      if (!(m_valid && b == m_code && m_ext == m_kext)) begin
        m_code = b; m_kext = m_ext; m_valid = 1; m_strobe = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
        m_ascii = ref_ascii(b, m_ext);
      end
      m_ext = 0;
    end
  endtask

  task automatic add(input logic [7:0] b, input bit long_gap);
    q_data.push_back(b);
    q_long.push_back(first_in_batch | long_gap);
    q_space.push_back(!(first_in_batch | long_gap));
    first_in_batch = 0;
    pushed++;
  endtask

  // One clock: check, emulate FIFO pop on nextdata_n low, drive next inputs.
  task automatic tick();
    logic [7:0] b;
    bit lg, sp;
    @(negedge clk);
    cyc++;
    if (pend_chk) begin
      check_eq("key_code", key_code, m_code);
      check_eq("key_ext", key_ext, m_kext);
      check_eq("key_valid", key_valid, m_valid);
      check_eq("key_strobe", key_strobe, m_strobe);
      check_eq("press_count", press_count, m_cnt);
      check_eq("ascii", ascii, m_ascii);
      pend_chk = 0;
    end else begin
      check_eq("strobe_quiet", key_strobe, 1'b0);
    end
    if (nextdata_n == 1'b0) begin
      if (q_data.size() == 0) begin
        check_eq("pop_empty", 32'd1, 32'd0);
      end else begin
        b = q_data.pop_front(); lg = q_long.pop_front(); sp = q_space.pop_front();
        if (sp && last_pop >= 0) check_eq("pop_space", cyc - last_pop, 3);
        last_pop = cyc;
        pops++;
        model_apply(b, lg);
        pend_chk = 1;
        hold = (q_data.size() > 0 && q_long[0]) ? 12 : 0;
      end
    end
    if (hold > 0) begin
      hold--;
      fifo_ready = 1'b0;
    end else begin
      fifo_ready = (q_data.size() > 0);
    end
    fifo_data = (q_data.size() > 0) ? q_data[0] : 8'h00;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q_data.size() > 0 || pend_chk) && budget < 3000) begin
      tick();
      budget++;
    end
    check_eq("drain_done", q_data.size(), 0);
    repeat (14) tick();
    first_in_batch = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ndn"}, nextdata_n, 1'b1);
    check_eq({tag, "_code"}, key_code, 8'h00);
    check_eq({tag, "_ext"}, key_ext, 1'b0);
    check_eq({tag, "_valid"}, key_valid, 1'b0);
    check_eq({tag, "_strobe"}, key_strobe, 1'b0);
    check_eq({tag, "_cnt"}, press_count, 0);
    check_eq({tag, "_ascii"}, ascii, 8'h00);
    check_eq({tag, "_ovf"}, ovf_sticky, 1'b0);
  endtask

  initial begin
    int n;
    bit found;
    resetn = 1'b0; fifo_ready = 1'b1; fifo_data = 8'h1C; fifo_overflow = 1'b0;
    first_in_batch = 1;
    model_reset();
    // reset with data waiting: no pop, reset values
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("rst");
    end
    resetn = 1'b1; fifo_ready = 1'b0;

    // directed sequences
    add(8'h1C, 0); drain();
    add(8'h1C, 0); add(8'h1C, 0); add(8'h1C, 0); add(8'hF0, 0); add(8'h1C, 0); drain();
    add(8'hE0, 0); add(8'h75, 0); drain();
    add(8'hE0, 0); add(8'hF0, 0); add(8'h75, 0); drain();
    add(8'hF0, 0); drain();
    add(8'h16, 0); drain();
    add(8'h1E, 0); drain(); add(8'h26, 0); drain();
    add(8'h25, 0); drain(); add(8'h2E, 0); drain();
    add(8'h1C, 0); add(8'h32, 0); add(8'h21, 0); add(8'h23, 0); add(8'hAA, 0); drain();
    add(8'hE0, 0); add(8'h1C, 1); add(8'hF0, 0); add(8'h29, 0); drain();

    // randomized batches
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 11) == 11) add(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
        else add(pool[$urandom_range(0, 10)], $urandom_range(0, 4) == 0);
      end
      drain();
    end
    check_eq("pop_total", pops, pushed);

    // overflow stickiness
    check_eq("ovf_before", ovf_sticky, 1'b0);
    fifo_overflow = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    repeat (5) begin
      tick();
      check_eq("ovf_sticky", ovf_sticky, 1'b1);
    end

    // reset asserted while a pop is in progress
    fifo_data = 8'h1C; fifo_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (nextdata_n == 1'b0) found = 1;
    end
    check_eq("midpop_seen", found, 1'b1);
    resetn = 1'b0; fifo_ready = 1'b0;
    #1;
    check_eq("midpop_ndn", nextdata_n, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("rst2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Consumer and sequencer for the ps2_keyboard receive FIFO.
- Pops one scan-code byte at a time using the ready/nextdata_n handshake.
- Decodes set-2 prefixes (0xE0 extended, 0xF0 break) into held-key state, a press counter and an optional ASCII code.
- Sits between ps2_keyboard and the seg/led display logic in top.

Parameters:
COUNT_W, 8, width of press_count; wraps modulo 2^COUNT_W
PREFIX_TIMEOUT, 1000000, clk cycles a pending prefix may wait for its next byte before being discarded; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
fifo_data  input  8  byte at FIFO head (ps2_keyboard data)
fifo_ready  input  1  FIFO non-empty
fifo_overflow  input  1  FIFO overflow flag from ps2_keyboard
nextdata_n  output  1  active-low pop request to ps2_keyboard
key_code  output  8  scan code of the currently/last held key
key_ext  output  1  key_code was preceded by 0xE0
key_valid  output  1  a key is currently held
key_strobe  output  1  one-cycle pulse on each new (non-repeat) make
press_count  output  COUNT_W  number of new makes since reset
ascii  output  8  ASCII of key_code (see Optional Feature)
ovf_sticky  output  1  sticky copy of fifo_overflow

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on resetn.
- Reset values: state=IDLE; nextdata_n=1; key_code=0x00; key_ext=0; key_valid=0; key_strobe=0; press_count=0; ascii=0x00; ovf_sticky=0; prefix flags and timeout counter cleared.
- nextdata_n is gated high whenever resetn=0, including reset asserted mid-POP.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if fifo_ready=1, capture fifo_data into byte_r and go to POP; otherwise stay.
  - POP: nextdata_n=0 for exactly this cycle; decode byte_r; register results at the end of the cycle; go to SETTLE.
  - SETTLE: nextdata_n=1; fifo_ready is ignored this cycle so the FIFO pointer can update; key_strobe=1 here only for a new make; go to IDLE.
- Timing: 3 cycles per byte. fifo_ready seen high at edge n → results visible from cycle n+2.
- Decode of byte_r in POP:
  - 0xE0: set ext_pend; reload the timeout counter.
  - 0xF0: set brk_pend; reload the timeout counter.
  - 0xAA, 0xFA, 0xEE with no prefix pending: ignored, no state change.
  - Other code c with brk_pend=1: if key_valid=1, c==key_code and ext_pend==key_ext, then key_valid←0. Otherwise ignore (release of a non-tracked key). key_code/key_ext keep their last value. Clear both flags.
  - Other code c with brk_pend=0: if key_valid=1, c==key_code and ext_pend==key_ext, treat as typematic repeat (no strobe, no count). Otherwise key_code←c, key_ext←ext_pend, key_valid←1, press_count←press_count+1 (wraps to 0), and key_strobe in SETTLE. Clear ext_pend.
  - A new make while another key is held replaces it; the older key is no longer tracked.
- Prefix timeout: while either flag is set and the FSM is in IDLE with fifo_ready=0, the counter decrements. At 0 both flags clear. Reloaded to PREFIX_TIMEOUT-1 on each prefix byte.
- ovf_sticky: set when fifo_overflow=1; cleared only by reset.

Optional Feature:
- Macro PS2_KEY_ASCII_EN.
- Defined: ascii is registered alongside key_code from a set-2 lookup, updated in the same edge as key_code.
  - Letters map to lower-case: 0x1C→0x61 'a', 0x32→0x62 'b', …, 0x1A→0x7A 'z'.
  - Digits: 0x45→0x30 '0', 0x16→0x31 '1', …, 0x46→0x39 '9'.
  - 0x29→0x20, 0x5A→0x0D.
  - Any key with key_ext=1, and any unlisted code, → 0x00.
- Undefined: no lookup logic; ascii tied to 0x00.

Test Plan:
- Reset and idle: hold resetn=0 for 2 cycles with fifo_ready=1 → nextdata_n=1 throughout; all outputs at reset values; no pop.
- Basic make: FIFO bytes 0x1C → exactly one nextdata_n low pulse; key_code=0x1C, key_valid=1, key_strobe one cycle, press_count=1, ascii=0x61 (0x00 without PS2_KEY_ASCII_EN).
- Repeat then release: 0x1C,0x1C,0x1C,0xF0,0x1C → press_count stays 1; key_strobe pulses once; key_valid=0 after the final byte; 5 pops total.
- Extended key: 0xE0,0x75 then 0xE0,0xF0,0x75 → key_code=0x75, key_ext=1, ascii=0x00, press_count+1; key_valid=0 at the end.
- Prefix timeout and wrap (COUNT_W=2, PREFIX_TIMEOUT=4): 0xF0, idle 10 cycles, then 0x16 → treated as a make, press_count=1. Four more distinct makes (0x1E,0x26,0x25,0x2E) → press_count wraps to 1.
- Back-to-back and overflow: fifo_ready held high with 4 queued bytes → pops spaced exactly 3 cycles. Pulse fifo_overflow one cycle → ovf_sticky=1 until the next reset.
